// File: rtl/riscv_core_lsu_demux_1to2_if.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_core_lsu_demux_1to2_if
//  Description : Bus bundle for the LSU 1-to-2 request/response demux.
//                Carries the LSU-side request/response handshake, the two
//                downstream target ports and the outstanding-request count.
//                Signal names are written from the demux's point of view
//                (i_* flows into the demux, o_* flows out of it).
//  Modports    : slave  - the demux itself
//                master - the environment (LSU plus both targets)
//  Revision    : 1.0 - initial release
// ============================================================================
interface riscv_core_lsu_demux_1to2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  // LSU request side
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic                    i_req_we;
  logic [DATA_WIDTH-1:0]   i_req_wdata;
  logic [DATA_WIDTH/8-1:0] i_req_be;

  // Downstream request side (fields broadcast to both ports)
  logic                    o_m0_req_valid;
  logic                    i_m0_req_ready;
  logic                    o_m1_req_valid;
  logic                    i_m1_req_ready;
  logic [ADDR_WIDTH-1:0]   o_req_addr;
  logic                    o_req_we;
  logic [DATA_WIDTH-1:0]   o_req_wdata;
  logic [DATA_WIDTH/8-1:0] o_req_be;

  // Downstream response side
  logic                    i_m0_rsp_valid;
  logic [DATA_WIDTH-1:0]   i_m0_rsp_rdata;
  logic                    o_m0_rsp_ready;
  logic                    i_m1_rsp_valid;
  logic [DATA_WIDTH-1:0]   i_m1_rsp_rdata;
  logic                    o_m1_rsp_ready;

  // LSU response side
  logic                    o_rsp_valid;
  logic [DATA_WIDTH-1:0]   o_rsp_rdata;
  logic                    i_rsp_ready;

  logic [c_CNT_W-1:0]      o_outstanding;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_be,
    output o_req_ready,
    output o_m0_req_valid, o_m1_req_valid,
    input  i_m0_req_ready, i_m1_req_ready,
    output o_req_addr, o_req_we, o_req_wdata, o_req_be,
    input  i_m0_rsp_valid, i_m0_rsp_rdata, i_m1_rsp_valid, i_m1_rsp_rdata,
    output o_m0_rsp_ready, o_m1_rsp_ready,
    output o_rsp_valid, o_rsp_rdata,
    input  i_rsp_ready,
    output o_outstanding
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_we, i_req_wdata, i_req_be,
    input  o_req_ready,
    input  o_m0_req_valid, o_m1_req_valid,
    output i_m0_req_ready, i_m1_req_ready,
    input  o_req_addr, o_req_we, o_req_wdata, o_req_be,
    output i_m0_rsp_valid, i_m0_rsp_rdata, i_m1_rsp_valid, i_m1_rsp_rdata,
    input  o_m0_rsp_ready, o_m1_rsp_ready,
    input  o_rsp_valid, o_rsp_rdata,
    output i_rsp_ready,
    input  o_outstanding
  );
endinterface
`default_nettype wire

// File: rtl/riscv_core_lsu_demux_1to2.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_core_lsu_demux_1to2
//  Description : Steers the LSU request stream to port 0 (data memory) or
//                port 1 (peripheral window) by address decode, and returns
//                responses to the LSU strictly in request order. A small
//                route-ID FIFO remembers the destination of every accepted
//                request; its head selects which port may answer next.
//  Ports       : i_clk  - clock, rising edge
//                i_rst  - asynchronous active-high reset
//                bus    - riscv_core_lsu_demux_1to2_if.slave: LSU request /
//                         response handshake, two target ports, and the
//                         outstanding-request count
//  Parameters  : DEPTH must be a power of two and at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_core_lsu_demux_1to2 #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_SIZE = 32'h0001_0000,
  parameter int                    DEPTH       = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  riscv_core_lsu_demux_1to2_if.slave   bus
);

  localparam int                   c_PTR_W = $clog2(DEPTH);
  localparam int                   c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0]   c_FULL  = c_CNT_W'(DEPTH);
  // Window bounds carried at one extra bit so BASE+SIZE cannot wrap when the
  // window touches the top of the address space.
  localparam logic [ADDR_WIDTH:0]  c_WIN_LO = {1'b0, PERIPH_BASE};
  localparam logic [ADDR_WIDTH:0]  c_WIN_HI = {1'b0, PERIPH_BASE} + {1'b0, PERIPH_SIZE};

  // Route-ID FIFO: one bit per entry, 1 = port 1.
  logic [DEPTH-1:0]      r_route;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic [ADDR_WIDTH:0]   w_addr_ext;
  logic                  w_sel;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_head;
  logic                  w_req_ready;
  logic                  w_rsp_valid;
  logic                  w_push;
  logic                  w_pop;

  // --------------------------------------------------------------------------
  // Address decode and request path
  // --------------------------------------------------------------------------
  assign w_addr_ext = {1'b0, bus.i_req_addr};
  assign w_sel      = (w_addr_ext >= c_WIN_LO) && (w_addr_ext < c_WIN_HI);

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  assign bus.o_m0_req_valid = bus.i_req_valid & ~w_sel & ~w_full;
  assign bus.o_m1_req_valid = bus.i_req_valid &  w_sel & ~w_full;

  // No same-cycle bypass: a full FIFO refuses even when a pop happens now.
  assign w_req_ready     = ~w_full & (w_sel ? bus.i_m1_req_ready : bus.i_m0_req_ready);
  assign bus.o_req_ready = w_req_ready;

  assign bus.o_req_addr  = bus.i_req_addr;
  assign bus.o_req_we    = bus.i_req_we;
  assign bus.o_req_wdata = bus.i_req_wdata;
  assign bus.o_req_be    = bus.i_req_be;

  assign w_push = bus.i_req_valid & w_req_ready;

  // --------------------------------------------------------------------------
  // Response path: only the port named by the FIFO head may hand back data;
  // the other port's ready is held low so an early response waits there.
  // --------------------------------------------------------------------------
  assign w_head = r_route[r_rd_ptr];

  assign w_rsp_valid     = ~w_empty & (w_head ? bus.i_m1_rsp_valid : bus.i_m0_rsp_valid);
  assign bus.o_rsp_valid = w_rsp_valid;
  assign bus.o_rsp_rdata = w_rsp_valid ? (w_head ? bus.i_m1_rsp_rdata : bus.i_m0_rsp_rdata)
                                       : '0;

  assign bus.o_m0_rsp_ready = ~w_empty & ~w_head & bus.i_rsp_ready;
  assign bus.o_m1_rsp_ready = ~w_empty &  w_head & bus.i_rsp_ready;

  assign w_pop = w_rsp_valid & bus.i_rsp_ready;

  assign bus.o_outstanding = r_count;

  // --------------------------------------------------------------------------
  // FIFO state
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_route  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_route[r_wr_ptr] <= w_sel;
        r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_lsu_demux_1to2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_core_lsu_demux_1to2
//  Description : Self-checking bench for riscv_core_lsu_demux_1to2. A
//                queue-based model of the outstanding requests predicts every
//                output each cycle; directed sequences add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_core_lsu_demux_1to2;

  localparam int DEPTH = 4;
  localparam logic [31:0] A0 = 32'h0000_0100;  // data memory
  localparam logic [31:0] A1 = 32'h1000_0004;  // peripheral window

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  riscv_core_lsu_demux_1to2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) bus ();
  riscv_core_lsu_demux_1to2_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) bus_hi ();

  riscv_core_lsu_demux_1to2 #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .PERIPH_BASE(32'h1000_0000), .PERIPH_SIZE(32'h0001_0000), .DEPTH(DEPTH)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  // Second instance whose window ends exactly at the top of the address space.
  riscv_core_lsu_demux_1to2 #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .PERIPH_BASE(32'hFFFF_0000), .PERIPH_SIZE(32'h0001_0000), .DEPTH(DEPTH)
  ) u_dut_hi (
    .i_clk(clk), .i_rst(rst), .bus(bus_hi)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: a queue of outstanding requests in issue order.
  // --------------------------------------------------------------------------
  typedef struct {
    bit          sel;
    logic [31:0] tag;
  } ent_t;

  typedef struct {
    bit          m0_req_valid;
    bit          m1_req_valid;
    bit          req_ready;
    bit          rsp_valid;
    logic [31:0] rsp_rdata;
    bit          m0_rsp_ready;
    bit          m1_rsp_ready;
    int          outstanding;
    bit          sel;
    bit          push;
    bit          pop;
  } exp_t;

  ent_t mq[$];

  function automatic bit in_window(logic [31:0] a, longint base, longint size);
    longint ax;
    ax = longint'({32'b0, a});
    return (ax >= base) && (ax < base + size);
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    bit   full;
    bit   empty;
    bit   head;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    head  = empty ? 1'b0 : mq[0].sel;
    e.sel          = in_window(bus.i_req_addr, 64'h1000_0000, 64'h0001_0000);
    e.m0_req_valid = bus.i_req_valid && !e.sel && !full;
    e.m1_req_valid = bus.i_req_valid &&  e.sel && !full;
    e.req_ready    = !full && (e.sel ? bus.i_m1_req_ready : bus.i_m0_req_ready);
    e.rsp_valid    = !empty && (head ? bus.i_m1_rsp_valid : bus.i_m0_rsp_valid);
    e.rsp_rdata    = !e.rsp_valid ? 32'h0 : (head ? bus.i_m1_rsp_rdata : bus.i_m0_rsp_rdata);
    e.m0_rsp_ready = !empty && !head && bus.i_rsp_ready;
    e.m1_rsp_ready = !empty &&  head && bus.i_rsp_ready;
    e.outstanding  = mq.size();
    e.push         = bus.i_req_valid && e.req_ready;
    e.pop          = e.rsp_valid && bus.i_rsp_ready;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      exp_t e;
      e = model_eval();
      if (e.pop) void'(mq.pop_front());
      if (e.push) mq.push_back('{sel: e.sel, tag: bus.i_req_wdata});
    end
  end

  // Compare process: every output against the model, every cycle.
  always @(negedge clk) begin
    exp_t e;
    e = model_eval();
    chk("m0_req_valid", bus.o_m0_req_valid, e.m0_req_valid);
    chk("m1_req_valid", bus.o_m1_req_valid, e.m1_req_valid);
    chk("req_ready",    bus.o_req_ready,    e.req_ready);
    chk("rsp_valid",    bus.o_rsp_valid,    e.rsp_valid);
    chk("rsp_rdata",    bus.o_rsp_rdata,    e.rsp_rdata);
    chk("m0_rsp_ready", bus.o_m0_rsp_ready, e.m0_rsp_ready);
    chk("m1_rsp_ready", bus.o_m1_rsp_ready, e.m1_rsp_ready);
    chk("outstanding",  bus.o_outstanding,  e.outstanding);
    chk("req_fields",   {bus.o_req_addr, bus.o_req_wdata},
                        {bus.i_req_addr, bus.i_req_wdata});
    chk("req_we_be",    {bus.o_req_we, bus.o_req_be}, {bus.i_req_we, bus.i_req_be});
    if (e.pop) chk("pop_order", bus.o_rsp_rdata, mq[0].tag);
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input logic [31:0] a, input logic [31:0] d);
    bus.i_req_valid = v;
    bus.i_req_addr  = a;
    bus.i_req_wdata = d;
    bus.i_req_we    = d[0];
    bus.i_req_be    = 4'hF;
  endtask

  task automatic set_rsp(input bit v0, input logic [31:0] d0, input bit v1, input logic [31:0] d1);
    bus.i_m0_rsp_valid = v0;
    bus.i_m0_rsp_rdata = d0;
    bus.i_m1_rsp_valid = v1;
    bus.i_m1_rsp_rdata = d1;
  endtask

  initial begin
    #100000;
    n_total++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    // Second instance: request only, targets never ready.
    bus_hi.i_req_valid = 1'b1;
    bus_hi.i_req_addr = 32'hFFFF_FFFC;
    bus_hi.i_req_we = 1'b0;
    bus_hi.i_req_wdata = '0;
    bus_hi.i_req_be = 4'hF;
    bus_hi.i_m0_req_ready = 1'b0;
    bus_hi.i_m1_req_ready = 1'b0;
    bus_hi.i_m0_rsp_valid = 1'b0;
    bus_hi.i_m0_rsp_rdata = '0;
    bus_hi.i_m1_rsp_valid = 1'b0;
    bus_hi.i_m1_rsp_rdata = '0;
    bus_hi.i_rsp_ready = 1'b0;

    // ---- Reset state (stray response present, FIFO empty) ----
    set_req(1'b1, A0, 32'h0);
    set_rsp(1'b1, 32'h1234, 1'b0, 32'h0);
    bus.i_m0_req_ready = 1'b1;
    bus.i_m1_req_ready = 1'b1;
    bus.i_rsp_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outstanding", bus.o_outstanding, 0);
    chk("rst_rsp_valid",   bus.o_rsp_valid, 0);
    chk("rst_m0_rsp_ready", bus.o_m0_rsp_ready, 0);
    chk("rst_req_ready",   bus.o_req_ready, 1);
    set_req(1'b0, A0, 32'h0);
    set_rsp(1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b0;

    // ---- Address decode (targets not ready, nothing accepted) ----
    bus.i_m0_req_ready = 1'b0;
    bus.i_m1_req_ready = 1'b0;
    tick();
    set_req(1'b1, 32'h0000_0100, 32'h0); #1;
    chk("dec_0100_m0", bus.o_m0_req_valid, 1);
    chk("dec_0100_m1", bus.o_m1_req_valid, 0);
    set_req(1'b1, 32'h1000_0004, 32'h0); #1;
    chk("dec_periph_m1", bus.o_m1_req_valid, 1);
    set_req(1'b1, 32'h1001_0000, 32'h0); #1;
    chk("dec_past_end_m0", bus.o_m0_req_valid, 1);
    set_req(1'b1, 32'h0FFF_FFFF, 32'h0); #1;
    chk("dec_below_m0", bus.o_m0_req_valid, 1);
    chk("dec_top_m1", bus_hi.o_m1_req_valid, 1);
    chk("dec_top_m0", bus_hi.o_m0_req_valid, 0);
    bus_hi.i_req_addr = 32'hFFFE_FFFC; #1;
    chk("dec_belowtop_m0", bus_hi.o_m0_req_valid, 1);
    set_req(1'b0, A0, 32'h0);

    // ---- Ordering: A to port 1, then B to port 0; port 0 answers first ----
    bus.i_m0_req_ready = 1'b1;
    bus.i_m1_req_ready = 1'b1;
    tick(); set_req(1'b1, 32'h1000_0000, 32'h0000_AAAA);
    tick(); set_req(1'b1, A0, 32'h0000_BBBB);
    tick(); set_req(1'b0, A0, 32'h0);
    set_rsp(1'b1, 32'h0000_BBBB, 1'b0, 32'h0); #1;
    chk("ord_outstanding", bus.o_outstanding, 2);
    chk("ord_m0_wait1", bus.o_m0_rsp_ready, 0);
    chk("ord_rsp_wait1", bus.o_rsp_valid, 0);
    tick(); #1;
    chk("ord_m0_wait2", bus.o_m0_rsp_ready, 0);
    tick(); set_rsp(1'b1, 32'h0000_BBBB, 1'b1, 32'h0000_AAAA); #1;
    chk("ord_first_data", bus.o_rsp_rdata, 32'h0000_AAAA);
    chk("ord_m1_ready", bus.o_m1_rsp_ready, 1);
    chk("ord_m0_wait3", bus.o_m0_rsp_ready, 0);
    tick(); set_rsp(1'b1, 32'h0000_BBBB, 1'b0, 32'h0); #1;
    chk("ord_second_data", bus.o_rsp_rdata, 32'h0000_BBBB);
    chk("ord_m0_ready", bus.o_m0_rsp_ready, 1);
    tick(); set_rsp(1'b1, 32'h0000_DEAD, 1'b1, 32'h0000_BEEF); #1;
    chk("ord_drained", bus.o_outstanding, 0);
    chk("stray_rsp_valid", bus.o_rsp_valid, 0);
    chk("stray_rdata", bus.o_rsp_rdata, 0);
    chk("stray_rdy", {bus.o_m0_rsp_ready, bus.o_m1_rsp_ready}, 2'b00);
    set_rsp(1'b0, 32'h0, 1'b0, 32'h0);

    // ---- Full: four accepted, fifth waits until the cycle after a pop ----
    for (int i = 0; i < 4; i++) begin
      tick(); set_req(1'b1, (i % 2) ? A1 : A0, 32'h10 + i); #1;
      chk("full_fill_ready", bus.o_req_ready, 1);
    end
    tick(); set_req(1'b1, A0, 32'h14); #1;
    chk("full_outstanding", bus.o_outstanding, 4);
    chk("full_ready", bus.o_req_ready, 0);
    chk("full_m0_valid", bus.o_m0_req_valid, 0);
    tick(); set_rsp(1'b1, 32'h10, 1'b0, 32'h0); #1;
    chk("full_pop_cycle_ready", bus.o_req_ready, 0);
    chk("full_pop_rsp", bus.o_rsp_rdata, 32'h10);
    tick(); set_rsp(1'b0, 32'h0, 1'b0, 32'h0); #1;
    chk("full_after_pop_cnt", bus.o_outstanding, 3);
    chk("full_after_pop_ready", bus.o_req_ready, 1);
    tick(); set_req(1'b0, A0, 32'h0); #1;
    chk("full_refilled", bus.o_outstanding, 4);
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (j % 2) set_rsp(1'b0, 32'h0, 1'b1, 32'h10 + j);
      else       set_rsp(1'b1, 32'h10 + j, 1'b0, 32'h0);
      #1;
      chk("full_drain_data", bus.o_rsp_rdata, 32'h10 + j);
    end
    tick(); set_rsp(1'b0, 32'h0, 1'b0, 32'h0); #1;
    chk("full_drained", bus.o_outstanding, 0);

    // ---- Back-to-back streaming across several pointer wraps ----
    for (int k = 0; k <= 16; k++) begin
      tick();
      set_req(k < 16, (k % 2) ? A1 : A0, 32'h100 + k);
      if (k == 0)            set_rsp(1'b0, 32'h0, 1'b0, 32'h0);
      else if ((k - 1) % 2)  set_rsp(1'b0, 32'h0, 1'b1, 32'h100 + k - 1);
      else                   set_rsp(1'b1, 32'h100 + k - 1, 1'b0, 32'h0);
      #1;
      if (k < 16) chk("stream_ready", bus.o_req_ready, 1);
      chk("stream_outstanding", bus.o_outstanding, (k == 0) ? 0 : 1);
      if (k >= 1) chk("stream_rdata", bus.o_rsp_rdata, 32'h100 + k - 1);
    end
    tick(); set_rsp(1'b0, 32'h0, 1'b0, 32'h0); #1;
    chk("stream_drained", bus.o_outstanding, 0);

    // ---- LSU backpressure ----
    tick(); set_req(1'b1, A1, 32'h55);
    tick(); set_req(1'b0, A0, 32'h0);
    set_rsp(1'b0, 32'h0, 1'b1, 32'h55);
    bus.i_rsp_ready = 1'b0; #1;
    chk("bp_rsp_valid", bus.o_rsp_valid, 1);
    chk("bp_m1_ready", bus.o_m1_rsp_ready, 0);
    tick(); #1;
    chk("bp_held", bus.o_outstanding, 1);
    bus.i_rsp_ready = 1'b1; #1;
    chk("bp_release_ready", bus.o_m1_rsp_ready, 1);
    tick(); set_rsp(1'b0, 32'h0, 1'b0, 32'h0); #1;
    chk("bp_popped", bus.o_outstanding, 0);

    // ---- Asynchronous reset with three outstanding ----
    tick(); set_req(1'b1, A0, 32'h20);
    tick(); set_req(1'b1, A1, 32'h21);
    tick(); set_req(1'b1, A0, 32'h22);
    tick(); set_req(1'b0, A0, 32'h0);
    bus.i_rsp_ready = 1'b0;
    set_rsp(1'b1, 32'h20, 1'b0, 32'h0); #1;
    chk("ar_pre_outstanding", bus.o_outstanding, 3);
    chk("ar_pre_rsp_valid", bus.o_rsp_valid, 1);
    rst = 1'b1; #1;
    chk("ar_outstanding", bus.o_outstanding, 0);
    chk("ar_rsp_valid", bus.o_rsp_valid, 0);
    tick();
    rst = 1'b0;
    set_rsp(1'b0, 32'h0, 1'b0, 32'h0);
    bus.i_rsp_ready = 1'b1;
    tick(); set_req(1'b1, A1, 32'h77); #1;
    chk("ar_fresh_ready", bus.o_req_ready, 1);
    tick(); set_req(1'b0, A0, 32'h0);
    set_rsp(1'b0, 32'h0, 1'b1, 32'h77); #1;
    chk("ar_fresh_cnt", bus.o_outstanding, 1);
    chk("ar_fresh_data", bus.o_rsp_rdata, 32'h77);
    tick(); set_rsp(1'b0, 32'h0, 1'b0, 32'h0); #1;
    chk("ar_fresh_done", bus.o_outstanding, 0);

    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_core_lsu_demux_1to2.md
# riscv_core_lsu_demux_1to2

Routes the load/store unit's single request stream to one of two downstream targets, port 0 (data memory) or port 1 (peripheral/MMIO region), chosen by address decode. It steers the returning responses back to the LSU in strict request order. A route-ID FIFO records the destination of every accepted request, so the LSU sees in-order responses even when the two targets have different latencies. It sits between the LSU/MEM stage and the memory/peripheral buses.

## Interface
Parameters:
- DATA_WIDTH, 32, request/response data width.
- ADDR_WIDTH, 32, address width.
- PERIPH_BASE, 32'h1000_0000, first address decoded to port 1.
- PERIPH_SIZE, 32'h0001_0000, size in bytes of the port-1 window.
- DEPTH, 4, maximum outstanding requests. Must be a power of two, ≥2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  LSU request valid.
- o_req_ready  out  1  request accepted this cycle when high together with i_req_valid.
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_wdata  in  DATA_WIDTH  store data.
- i_req_be  in  DATA_WIDTH/8  byte enables.
- o_mN_req_valid (N=0,1)  out  1  request valid to port N.
- i_mN_req_ready (N=0,1)  in  1  port N accepts request.
- o_req_addr, o_req_we, o_req_wdata, o_req_be  out  as inputs  request fields, broadcast to both ports.
- i_mN_rsp_valid (N=0,1)  in  1  port N response valid.
- i_mN_rsp_rdata (N=0,1)  in  DATA_WIDTH  port N load data (don't-care for stores).
- o_mN_rsp_ready (N=0,1)  out  1  port N response accepted.
- o_rsp_valid  out  1  response valid to LSU.
- o_rsp_rdata  out  DATA_WIDTH  response data to LSU.
- i_rsp_ready  in  1  LSU accepts response.
- o_outstanding  out  $clog2(DEPTH)+1  number of requests accepted but not yet answered.

## Operation
- Decode: sel = 1 iff PERIPH_BASE ≤ addr < PERIPH_BASE+PERIPH_SIZE. The upper-bound sum is computed at ADDR_WIDTH+1 bits so it cannot wrap; otherwise sel = 0.
- full = (count == DEPTH); empty = (count == 0).
- Request path is combinational:
  - o_mN_req_valid = i_req_valid & (sel==N) & !full.
  - o_req_ready = !full & i_mN_req_ready for the selected N.
  - Request fields pass straight through.
- Push: on an accepted request (i_req_valid & o_req_ready), write sel into fifo[wr_ptr], wr_ptr++ (modulo DEPTH).
- Every request, load or store, produces exactly one downstream response.
- Response path is combinational, driven by head = fifo[rd_ptr]:
  - o_rsp_valid = !empty & i_m<head>_rsp_valid.
  - o_rsp_rdata = i_m<head>_rsp_rdata. It is 0 when o_rsp_valid is low.
  - o_m<head>_rsp_ready = !empty & i_rsp_ready.
  - The non-head port's rsp_ready is held 0, so an early response from that port waits in the target.
- Pop: on o_rsp_valid & i_rsp_ready, rd_ptr++ (modulo DEPTH).
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. o_outstanding = count.
- Full: there is no same-cycle bypass. While count==DEPTH, o_req_ready=0 even if a pop occurs that cycle. Acceptance resumes the next cycle.
- Empty: o_rsp_valid=0 and both rsp_ready=0. Stray responses are not consumed.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Ordering must hold across wrap.

## Timing
- Reset (async assert, sync to i_clk on release): count=0, wr_ptr=rd_ptr=0, FIFO contents cleared to 0. Resulting outputs: o_outstanding=0, o_rsp_valid=0, o_m0/1_rsp_ready=0. Request outputs follow the inputs combinationally; o_req_ready reflects target readiness since the FIFO is not full.
- Reset mid-operation: all outstanding route IDs are discarded. Downstream targets share i_rst, so no late responses are expected.
- Latency: 0 cycles added on both the request path and the response path. Internal state updates at the clock edge after a handshake.
- Throughput: one request and one response per cycle, sustained while not full and not empty.

## Test plan
- Address decode: addr 0x0000_0100 → o_m0_req_valid=1; addr 0x1000_0004 → o_m1_req_valid=1; addr 0x1001_0000 (one past the window) → port 0; addr 0xFFFF_FFFC with PERIPH_BASE=0xFFFF_0000 and PERIPH_SIZE=0x1_0000 → port 1, with no wrap error.
- Ordering: issue req A to port 1, then req B to port 0. Port 0 responds first with 0xBBBB and port 1 responds two cycles later with 0xAAAA. Required: o_m0_rsp_ready stays 0 until A completes, and the LSU sees 0xAAAA then 0xBBBB.
- Full: DEPTH=4, issue 4 requests with no responses → o_outstanding=4 and o_req_ready=0. Then pop one while a 5th is pending → the 5th is accepted on the following cycle, not the pop cycle.
- Back-to-back streaming: 16 alternating-port requests, each answered in 1 cycle, with i_rsp_ready=1. Required: one accept per cycle after fill, data returned in order, correct across ≥3 pointer wraps.
- LSU backpressure: i_rsp_ready=0 with a head response valid → o_m<head>_rsp_ready=0 and count held. Releasing i_rsp_ready → pop completes in that cycle.
- Async reset: assert i_rst mid-cycle with 3 outstanding → o_outstanding=0 and o_rsp_valid=0 immediately, before the next edge. After release, a fresh request is accepted normally.
